uart_tx_fifo: RTL and testbench

UART transmitter with a small input FIFO: the transmit end of the serial link whose receive end drives `wave_select` / `white_noise_en` in the wave generator. It lets the design send status or echo bytes back to the host at the same 8N1 framing and 9600-baud rate (25 MHz clock). Bytes enter through a valid/ready handshake, are buffered, and are serialized LSB-first on a registered `tx` line.

---
 rtl/uart_tx_fifo.sv | 139 +++++++++++++
 tb/tb_uart_tx_fifo.sv | 273 +++++++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// 8N1 UART transmitter fed by a small circular-buffer FIFO.
// Bytes are accepted on a valid/ready handshake and shifted out LSB first on a registered tx line.
module uart_tx_fifo #(
    parameter int CLKS_PER_BIT = 2604,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                        clk,
    input  logic                        rst_n,
    input  logic [7:0]                  tx_data,
    input  logic                        tx_valid,
    output logic                        tx_ready,
    output logic                        tx,
    output logic                        tx_busy,
    output logic [$clog2(FIFO_DEPTH):0] fifo_count
);

    localparam int PW = $clog2(FIFO_DEPTH);
    localparam int BW = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
    localparam logic [BW-1:0] BAUD_LAST = BW'(CLKS_PER_BIT - 1);
    localparam logic [PW:0]   FULL      = (PW + 1)'(FIFO_DEPTH);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t        state, state_n;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [PW-1:0] wr_ptr, rd_ptr;
    logic [PW:0]   count;
    logic          push, pop, has_data;
    logic [BW-1:0] baud, baud_n;
    logic [2:0]    bit_idx, bit_idx_n;
    logic [7:0]    shift, shift_n;
    logic          tx_n;

    // Handshake: a byte transfers on a rising edge where tx_valid and tx_ready are both high;
    // tx_valid with tx_ready low is simply ignored.
    assign tx_ready   = (count != FULL);
    assign push       = tx_valid & tx_ready;
    assign has_data   = (count != '0);
    assign fifo_count = count;
    assign tx_busy    = (state != IDLE) || has_data;

    always_ff @(posedge clk) begin
        if (push) mem[wr_ptr] <= tx_data;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + 1'b1;
            if (pop)  rd_ptr <= rd_ptr + 1'b1;
            case ({push, pop})
                2'b10:   count <= count + 1'b1;
                2'b01:   count <= count - 1'b1;
                default: count <= count;
            endcase
        end
    end

    always_comb begin
        state_n   = state;
        baud_n    = baud;
        bit_idx_n = bit_idx;
        shift_n   = shift;
        pop       = 1'b0;
        case (state)
            IDLE: begin
                if (has_data) begin
                    pop       = 1'b1;
                    shift_n   = mem[rd_ptr];
                    bit_idx_n = '0;
                    baud_n    = '0;
                    state_n   = START;
                end
            end
            START: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    state_n = DATA;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            DATA: begin
                if (baud == BAUD_LAST) begin
                    baud_n  = '0;
                    shift_n = {1'b0, shift[7:1]};
                    if (bit_idx == 3'd7) state_n = STOP;
                    else                 bit_idx_n = bit_idx + 1'b1;
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            STOP: begin
                if (baud == BAUD_LAST) begin
                    baud_n = '0;
                    // Chain straight into the next start bit when more bytes are waiting.
                    if (has_data) begin
                        pop       = 1'b1;
                        shift_n   = mem[rd_ptr];
                        bit_idx_n = '0;
                        state_n   = START;
                    end else begin
                        state_n = IDLE;
                    end
                end else begin
                    baud_n = baud + 1'b1;
                end
            end
            default: state_n = IDLE;
        endcase

        // Line level is computed from the next state so the flop lines up with the state register.
        case (state_n)
            START:   tx_n = 1'b0;
            DATA:    tx_n = shift_n[0];
            default: tx_n = 1'b1;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state   <= IDLE;
            baud    <= '0;
            bit_idx <= '0;
            shift   <= '0;
            tx      <= 1'b1;
        end else begin
            state   <= state_n;
            baud    <= baud_n;
            bit_idx <= bit_idx_n;
            shift   <= shift_n;
            tx      <= tx_n;
        end
    end

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: a default-rate instance for one full-speed frame and a
// CLKS_PER_BIT=4 instance for table vectors, back-to-back, overflow, reset and receiver checks.
module tb_uart_tx_fifo;

    logic       clk = 1'b0;
    always #20 clk = ~clk;

    logic       rst_b_n, valid_b, ready_b, tx_b, busy_b;
    logic [7:0] data_b;
    logic [2:0] cnt_b;
    logic       rst_s_n, valid_s, ready_s, tx_s, busy_s;
    logic [7:0] data_s;
    logic [2:0] cnt_s;

    uart_tx_fifo #(.CLKS_PER_BIT(2604), .FIFO_DEPTH(4)) u_big (
        .clk(clk), .rst_n(rst_b_n), .tx_data(data_b), .tx_valid(valid_b),
        .tx_ready(ready_b), .tx(tx_b), .tx_busy(busy_b), .fifo_count(cnt_b)
    );

    uart_tx_fifo #(.CLKS_PER_BIT(4), .FIFO_DEPTH(4)) u_small (
        .clk(clk), .rst_n(rst_s_n), .tx_data(data_s), .tx_valid(valid_s),
        .tx_ready(ready_s), .tx(tx_s), .tx_busy(busy_s), .fifo_count(cnt_s)
    );

    typedef struct {
        logic [7:0] data;
        logic [9:0] frame;
    } vec_t;

    vec_t       vecs [8];
    logic [9:0] exp_q [$];
    int         checks = 0;
    int         errors = 0;
    logic [2:0] snap_cnt_a, snap_cnt_b;
    logic       snap_rdy_a, snap_rdy_b;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic push_s(input logic [7:0] d);
        @(negedge clk);
        data_s  = d;
        valid_s = 1'b1;
        @(negedge clk);
        valid_s = 1'b0;
    endtask

    // Cycle-exact line/busy check against the frames in exp_q; t counts negedges after the first push edge.
    task automatic run_line(input bit big, input int cpb, input int t0, input int tail, input string name);
        int   n, last_busy, bad_tx, bad_busy, first_bad, k, f, b;
        logic e_tx, a_tx, a_busy;
        n = exp_q.size();
        last_busy = n * 10 * cpb;
        bad_tx = 0; bad_busy = 0; first_bad = -1;
        for (int t = t0; t <= last_busy + tail; t++) begin
            if (t != t0) @(negedge clk);
            if (t == 0) e_tx = 1'b1;
            else begin
                k = (t - 1) / cpb;
                f = k / 10;
                b = k % 10;
                e_tx = (f < n) ? exp_q[f][b] : 1'b1;
            end
            a_tx   = big ? tx_b : tx_s;
            a_busy = big ? busy_b : busy_s;
            if (a_tx !== e_tx) begin
                bad_tx++;
                if (first_bad < 0) first_bad = t;
            end
            if (a_busy !== (t <= last_busy)) bad_busy++;
            if (t == 10 * cpb) begin
                snap_cnt_a = big ? cnt_b : cnt_s;
                snap_rdy_a = big ? ready_b : ready_s;
            end
            if (t == 10 * cpb + 1) begin
                snap_cnt_b = big ? cnt_b : cnt_s;
                snap_rdy_b = big ? ready_b : ready_s;
            end
        end
        if (bad_tx != 0) $display("first tx deviation of %s at cycle %0d", name, first_bad);
        check({name, "_tx_bad_cycles"}, bad_tx, 0);
        check({name, "_busy_bad_cycles"}, bad_busy, 0);
        exp_q.delete();
    endtask

    initial begin
        #(40 * 200000);
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        vecs[0] = '{8'h54, 10'h2A8};
        vecs[1] = '{8'h53, 10'h2A6};
        vecs[2] = '{8'h00, 10'h200};
        vecs[3] = '{8'hFF, 10'h3FE};
        vecs[4] = '{8'hA5, 10'h34A};
        vecs[5] = '{8'h01, 10'h202};
        vecs[6] = '{8'h80, 10'h300};
        vecs[7] = '{8'h3C, 10'h278};

        rst_b_n = 1'b0; valid_b = 1'b0; data_b = '0;
        rst_s_n = 1'b0; valid_s = 1'b0; data_s = '0;
        repeat (3) @(negedge clk);
        check("reset_tx_b", tx_b, 1);
        check("reset_ready_b", ready_b, 1);
        check("reset_busy_b", busy_b, 0);
        check("reset_cnt_b", cnt_b, 0);
        rst_b_n = 1'b1;
        rst_s_n = 1'b1;
        @(negedge clk);
        check("reset_tx_s", tx_s, 1);
        check("reset_ready_s", ready_s, 1);
        check("reset_busy_s", busy_s, 0);
        check("reset_cnt_s", cnt_s, 0);

        // Single-byte frames from the table
        foreach (vecs[i]) begin
            push_s(vecs[i].data);
            check($sformatf("vec%0d_cnt", i), cnt_s, 1);
            exp_q.push_back(vecs[i].frame);
            run_line(1'b0, 4, 0, 3, $sformatf("vec%0d", i));
        end

        // Back-to-back 0x54, 0x53
        @(negedge clk);
        data_s = 8'h54; valid_s = 1'b1;
        @(negedge clk);
        check("b2b_cnt_t0", cnt_s, 1);
        check("b2b_tx_t0", tx_s, 1);
        data_s = 8'h53;
        @(negedge clk);
        valid_s = 1'b0;
        check("b2b_cnt_t1", cnt_s, 1);
        exp_q.push_back(10'h2A8);
        exp_q.push_back(10'h2A6);
        run_line(1'b0, 4, 1, 3, "b2b");
        check("b2b_cnt_end_first", snap_cnt_a, 1);
        check("b2b_cnt_after_pop", snap_cnt_b, 0);

        // Overflow: six bytes A..F on consecutive cycles
        @(negedge clk);
        valid_s = 1'b1; data_s = 8'h41;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            data_s = 8'h41 + 8'(i);
        end
        check("ovf_ready_low", ready_s, 0);
        check("ovf_cnt_full", cnt_s, 4);
        @(negedge clk);
        valid_s = 1'b0;
        check("ovf_drop_cnt", cnt_s, 4);
        for (int i = 0; i < 5; i++) begin
            logic [7:0] d;
            d = 8'h41 + 8'(i);
            exp_q.push_back({1'b1, d, 1'b0});
        end
        run_line(1'b0, 4, 5, 3, "ovf");
        check("ovf_cnt_last_stop", snap_cnt_a, 4);
        check("ovf_ready_last_stop", snap_rdy_a, 0);
        check("ovf_cnt_after_pop", snap_cnt_b, 3);
        check("ovf_ready_after_pop", snap_rdy_b, 1);

        // Reset during data bit 3 with two bytes queued
        @(negedge clk);
        valid_s = 1'b1; data_s = 8'h00;
        @(negedge clk);
        data_s = 8'h5A;
        @(negedge clk);
        data_s = 8'hC3;
        @(negedge clk);
        valid_s = 1'b0;
        repeat (16) @(negedge clk);
        check("rst_pre_tx", tx_s, 0);
        check("rst_pre_cnt", cnt_s, 2);
        rst_s_n = 1'b0;
        #1;
        check("rst_async_tx", tx_s, 1);
        check("rst_async_cnt", cnt_s, 0);
        check("rst_async_busy", busy_s, 0);
        check("rst_async_ready", ready_s, 1);
        @(negedge clk);
        rst_s_n = 1'b1;
        begin
            int bad;
            bad = 0;
            repeat (60) begin
                @(negedge clk);
                if (tx_s !== 1'b1 || busy_s !== 1'b0 || cnt_s !== 3'd0) bad++;
            end
            check("rst_post_idle_bad_cycles", bad, 0);
        end

        // All 256 values through a mid-bit sampling receiver
        fork
            begin : drv
                int  waitc;
                bit  acc;
                @(negedge clk);
                for (int v = 0; v < 256; v++) begin
                    data_s  = v[7:0];
                    valid_s = 1'b1;
                    acc     = 1'b0;
                    waitc   = 0;
                    while (!acc && waitc < 200) begin
                        acc = ready_s;
                        @(negedge clk);
                        waitc++;
                    end
                    if (!acc) begin
                        check("rx256_push_timeout", 1, 0);
                        break;
                    end
                end
                valid_s = 1'b0;
            end
            begin : rcv
                int         w, bad_byte, bad_frame;
                logic [7:0] rx;
                logic       sb, pb;
                bad_byte = 0; bad_frame = 0;
                for (int k = 0; k < 256; k++) begin
                    w = 0;
                    while (tx_s !== 1'b0 && w < 200) begin
                        @(negedge clk);
                        w++;
                    end
                    if (tx_s !== 1'b0) begin
                        check("rx256_start_timeout", k, 256);
                        break;
                    end
                    repeat (2) @(negedge clk);
                    sb = tx_s;
                    for (int i = 0; i < 8; i++) begin
                        repeat (4) @(negedge clk);
                        rx[i] = tx_s;
                    end
                    repeat (4) @(negedge clk);
                    pb = tx_s;
                    if (rx !== k[7:0]) begin
                        if (bad_byte == 0) $display("rx256 first wrong byte index %0d got %0h", k, rx);
                        bad_byte++;
                    end
                    if (sb !== 1'b0 || pb !== 1'b1) bad_frame++;
                end
                check("rx256_bad_bytes", bad_byte, 0);
                check("rx256_bad_framing", bad_frame, 0);
            end
        join
        repeat (10) @(negedge clk);
        check("rx256_idle_busy", busy_s, 0);
        check("rx256_idle_cnt", cnt_s, 0);

        // Full-rate single byte 0x54 on the default instance
        @(negedge clk);
        data_b = 8'h54; valid_b = 1'b1;
        @(negedge clk);
        valid_b = 1'b0;
        check("big_cnt_t0", cnt_b, 1);
        exp_q.push_back(10'h2A8);
        run_line(1'b1, 2604, 0, 5, "big_0x54");
        check("big_cnt_end", cnt_b, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
